// File: rtl/avalon_onchip_ram_dp.sv
// avalon_onchip_ram_dp: true-dual-port Avalon-MM on-chip RAM with
// pipelined reads, write-collision arbitration and zero-fill.
module avalon_onchip_ram_dp #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 13,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_done
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t START = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  clocken;
  logic                  busy;
  logic                  collide;
  logic                  clear_we;
  logic                  s1_acc;
  logic                  s2_acc;
  logic                  s1_do_wr;
  logic                  s2_do_wr;
  logic [1:0]            do_rd;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign clocken  = clken & ~reset_req;
  assign busy     = ~clocken | (state_q == CLEAR);
  assign clear_we = clocken & (state_q == CLEAR);

  // Same-address double write: s1 wins, s2 is held off this cycle.
  assign collide = s1_chipselect & s1_write &
                   s2_chipselect & s2_write &
                   (s1_address == s2_address);

  assign s1_waitrequest = busy;
  assign s2_waitrequest = busy | collide;

  assign s1_acc = s1_chipselect & (s1_read | s1_write) &
                  ~s1_waitrequest & clocken;
  assign s2_acc = s2_chipselect & (s2_read | s2_write) &
                  ~s2_waitrequest & clocken;

  assign s1_do_wr = s1_acc & s1_write;
  assign s2_do_wr = s2_acc & s2_write;
  assign do_rd[0] = s1_acc & s1_read & ~s1_write;
  assign do_rd[1] = s2_acc & s2_read & ~s2_write;

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clocken && (&cnt_q))
      state_d = READY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= START;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (clear_we)
        cnt_q <= cnt_q + 1'b1;
      init_done <= (state_d == READY);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int b = 0; b < BE_W; b++) begin
        if (s2_do_wr && s2_byteenable[b])
          mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
        if (s1_do_wr && s1_byteenable[b])
          mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
    end
  end

  logic [1:0]            v1;
  logic [DATA_WIDTH-1:0] d1 [2];
  logic [1:0]            rv;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= '0;
      d1[0] <= '0;
      d1[1] <= '0;
    end else if (clocken) begin
      v1 <= do_rd;
      if (do_rd[0]) d1[0] <= mem[s1_address];
      if (do_rd[1]) d1[1] <= mem[s2_address];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            v2;
    logic [DATA_WIDTH-1:0] d2 [2];

    always_ff @(posedge clk) begin
      if (reset) begin
        v2    <= '0;
        d2[0] <= '0;
        d2[1] <= '0;
      end else if (clocken) begin
        v2 <= v1;
        if (v1[0]) d2[0] <= d1[0];
        if (v1[1]) d2[1] <= d1[1];
      end
    end

    assign rv          = v2;
    assign s1_readdata = d2[0];
    assign s2_readdata = d2[1];
  end else begin : g_lat1
    assign rv          = v1;
    assign s1_readdata = d1[0];
    assign s2_readdata = d1[1];
  end

  // A stalled result stays queued and is presented on the next enabled cycle.
  assign s1_readdatavalid = rv[0] & clocken;
  assign s2_readdatavalid = rv[1] & clocken;

endmodule

// File: tb/tb_avalon_onchip_ram_dp.sv
// tb_avalon_onchip_ram_dp: scoreboard bench, array reference model,
// directed scenarios followed by randomized dual-port traffic.
module tb_avalon_onchip_ram_dp;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  typedef struct {
    bit          cs;
    bit          rd;
    bit          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, reset_req, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [DW-1:0] s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid;
  logic          s1_waitrequest, s2_waitrequest;
  logic          init_done;

  always #5 clk = ~clk;

  avalon_onchip_ram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT),
    .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .init_done(init_done)
  );

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] model [DEPTH];
  exp_t          q1[$];
  exp_t          q2[$];
  int            ce_cnt = 0;
  int            cyc_ce = -1;
  int            clr_left = 0;
  bit            init_exp = 0;
  bit            acc1, acc2;
  bit            mon_en = 0;
  req_t          idle;

  task automatic chk(input string name, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic req_t mk(input bit rd, input bit wr, input int a,
                              input logic [3:0] be, input logic [DW-1:0] wd);
    req_t r;
    r.cs = 1'b1; r.rd = rd; r.wr = wr;
    r.addr = AW'(a); r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rnd();
    req_t r;
    int op;
    r.cs   = ($urandom_range(3) != 0);
    op     = $urandom_range(3);
    r.rd   = (op == 1 || op == 3);
    r.wr   = (op == 2 || op == 3);
    r.addr = ($urandom_range(1) != 0) ? AW'($urandom_range(3))
                                      : AW'($urandom_range(DEPTH - 1));
    r.be   = 4'($urandom_range(15));
    r.wd   = $urandom;
    return r;
  endfunction

  task automatic wr_model(input req_t r);
    for (int i = 0; i < 4; i++)
      if (r.be[i]) model[r.addr][i*8 +: 8] = r.wd[i*8 +: 8];
  endtask

  // One clock cycle: drive, check handshake, update the reference model.
  task automatic cyc(input req_t a, input req_t b, input bit ce_in,
                     input bit rr, input bit rst);
    bit ce, busy, col;
    exp_t e;
    @(negedge clk);
    reset = rst; reset_req = rr; clken = ce_in;
    s1_chipselect = a.cs; s1_read = a.rd; s1_write = a.wr;
    s1_address = a.addr; s1_byteenable = a.be; s1_writedata = a.wd;
    s2_chipselect = b.cs; s2_read = b.rd; s2_write = b.wr;
    s2_address = b.addr; s2_byteenable = b.be; s2_writedata = b.wd;
    #1;
    ce = ce_in & ~rr;
    cyc_ce = ce ? ce_cnt : -1;
    acc1 = 0; acc2 = 0;
    if (!rst) begin
      busy = !ce || (clr_left > 0);
      col  = a.cs && a.wr && b.cs && b.wr && (a.addr == b.addr);
      chk("s1_waitrequest", DW'(s1_waitrequest), DW'(busy));
      chk("s2_waitrequest", DW'(s2_waitrequest), DW'(busy || col));
      chk("init_done", DW'(init_done), DW'(init_exp));
      acc1 = a.cs && (a.rd || a.wr) && !busy;
      acc2 = b.cs && (b.rd || b.wr) && !busy && !col;
      if (acc1 && a.rd && !a.wr) begin
        e.data = model[a.addr]; e.due = ce_cnt + LAT; q1.push_back(e);
      end
      if (acc2 && b.rd && !b.wr) begin
        e.data = model[b.addr]; e.due = ce_cnt + LAT; q2.push_back(e);
      end
      if (acc2 && b.wr) wr_model(b);
      if (acc1 && a.wr) wr_model(a);
    end
    @(posedge clk);
    if (rst) begin
      clr_left = DEPTH;
      init_exp = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      q1.delete(); q2.delete();
    end else begin
      if (ce) begin
        if (clr_left > 0) clr_left--;
        ce_cnt++;
      end
      init_exp = (clr_left == 0);
    end
  endtask

  task automatic pop_chk(input int p, input logic [DW-1:0] got);
    exp_t e;
    total++;
    if ((p == 1 && q1.size() == 0) || (p == 2 && q2.size() == 0)) begin
      bad++;
      $display("FAIL s%0d_spurious_valid got=%h exp=none", p, got);
      return;
    end
    if (p == 1) e = q1.pop_front();
    else e = q2.pop_front();
    if (got !== e.data || cyc_ce != e.due) begin
      bad++;
      $display("FAIL s%0d_read got=%h@%0d exp=%h@%0d",
               p, got, cyc_ce, e.data, e.due);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (s1_readdatavalid) pop_chk(1, s1_readdata);
        if (s2_readdatavalid) pop_chk(2, s2_readdata);
      end
    end
  end

  task automatic drain();
    repeat (LAT + 3) cyc(idle, idle, 1, 0, 0);
  endtask

  initial begin
    req_t r1, r2;
    idle = '{cs: 0, rd: 0, wr: 0, addr: '0, be: '0, wd: '0};
    reset = 1; reset_req = 0; clken = 1;
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0;
    s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0;
    s2_byteenable = '0; s2_writedata = '0;

    cyc(idle, idle, 1, 0, 1);
    cyc(idle, idle, 1, 0, 1);
    #1;
    chk("rst_s1_readdata", s1_readdata, '0);
    chk("rst_s2_readdata", s2_readdata, '0);
    chk("rst_valid", DW'({s1_readdatavalid, s2_readdatavalid}), '0);
    mon_en = 1;
    repeat (DEPTH + 1) cyc(idle, idle, 1, 0, 0);

    for (int i = 0; i < DEPTH; i++)
      cyc(mk(1, 0, i, 4'h0, '0), mk(1, 0, DEPTH - 1 - i, 4'h0, '0), 1, 0, 0);
    drain();

    cyc(mk(0, 1, 5, 4'hF, 32'hDEADBEEF), idle, 1, 0, 0);
    cyc(mk(0, 1, 6, 4'hF, 32'h0BADF00D), idle, 1, 0, 0);
    cyc(mk(1, 0, 5, 4'h0, '0), idle, 1, 0, 0);
    cyc(mk(1, 0, 6, 4'h0, '0), idle, 1, 0, 0);
    drain();

    cyc(mk(0, 1, 9, 4'hF, 32'hAAAAAAAA), idle, 1, 0, 0);
    cyc(mk(0, 1, 9, 4'b0101, 32'h11223344), idle, 1, 0, 0);
    cyc(mk(1, 0, 9, 4'h0, '0), idle, 1, 0, 0);
    drain();

    cyc(mk(0, 1, 7, 4'hF, 32'h1), mk(0, 1, 7, 4'hF, 32'h2), 1, 0, 0);
    chk("collide_s2_held", DW'(acc2), '0);
    cyc(idle, mk(0, 1, 7, 4'hF, 32'h2), 1, 0, 0);
    cyc(mk(1, 0, 7, 4'h0, '0), mk(1, 0, 7, 4'h0, '0), 1, 0, 0);
    drain();

    cyc(mk(0, 1, 3, 4'hF, 32'h55), mk(1, 0, 3, 4'h0, '0), 1, 0, 0);
    cyc(mk(1, 0, 2, 4'h0, '0), mk(0, 1, 2, 4'hF, 32'h66), 1, 0, 0);
    cyc(mk(1, 0, 3, 4'h0, '0), mk(1, 0, 2, 4'h0, '0), 1, 0, 0);
    drain();

    cyc(mk(1, 0, 5, 4'h0, '0), idle, 1, 0, 0);
    repeat (3)
      cyc(mk(1, 0, 6, 4'h0, '0), mk(0, 1, 6, 4'hF, 32'h77), 0, 0, 0);
    cyc(idle, idle, 0, 1, 0);
    drain();

    cyc(idle, idle, 1, 0, 1);
    cyc(idle, idle, 1, 0, 1);
    repeat (9) cyc(idle, idle, 1, 0, 0);
    cyc(idle, idle, 1, 0, 1);
    repeat (DEPTH + 2) cyc(idle, idle, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cyc(mk(1, 0, i, 4'h0, '0), idle, 1, 0, 0);
    drain();

    r1 = rnd();
    r2 = rnd();
    for (int n = 0; n < 800; n++) begin
      cyc(r1, r2, $urandom_range(9) != 0, $urandom_range(29) == 0, 0);
      if (acc1 || !(r1.cs && (r1.rd || r1.wr))) r1 = rnd();
      if (acc2 || !(r2.cs && (r2.rd || r2.wr))) r2 = rnd();
    end
    drain();
    chk("q1_empty", DW'(q1.size()), '0);
    chk("q2_empty", DW'(q2.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
